bit_select_seq: RTL

//   Iterative "select" unit, the inverse of the ALU popcount (rank) operation:

---
 rtl/bit_select_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/bit_select_seq.sv
// Iterative select unit: returns the bit position of the n-th set bit (LSB first)
// of a captured operand, scanning one bit per cycle with a start/done handshake.
module bit_select_seq #(
  parameter int WIDTH = 32,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [5:0]       n,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [31:0]      pos
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [5:0]       n_q, n_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW:0]    cnt_q, cnt_d;
  logic             found_q, found_d;
  logic [IDXW-1:0]  pos_q, pos_d;

  logic hit_bit, rank_match, last_bit;

  assign hit_bit    = a_q[idx_q];
  // cnt never exceeds WIDTH, so ranks >= WIDTH can never compare equal.
  assign rank_match = (6'(cnt_q) == n_q);
  assign last_bit   = (idx_q == IDXW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    n_d     = n_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    pos_d   = pos_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          n_d     = n;
          idx_d   = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          pos_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit_bit && rank_match) begin
          pos_d   = idx_q;
          found_d = 1'b1;
          state_d = DONE;
        end else begin
          if (hit_bit) cnt_d = cnt_q + 1'b1;
          if (last_bit) begin
            found_d = 1'b0;
            pos_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign found = found_q;
  assign pos   = 32'(pos_q);

endmodule
